// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Purpose
//   Execute-stage ALU for a five-stage MIPS-style pipeline. Decodes the ALU
//   operation from the EX-stage opcode/funct pair and computes a
//   combinational result and zero flag. Registers both into the EX/MEM
//   pipeline register unless stalled. Also provides the ID-stage
//   branch-operand forwarding selects used by the early branch comparator.
//
// Configuration
//   ALU_SLT_EN : when defined, alu_ctrl 111 performs a signed set-less-than,
//                and funct 0x2A / opcode 0x0A decode to 111.
//                When undefined, those encodings decode to ADD (010), and
//                alu_ctrl 111 produces zero.
//
// Ports
//   clock          in   rising-edge clock
//   reset_n        in   asynchronous active-low reset (EX/MEM registers only)
//   stall          in   1 = hold EX/MEM registers
//   ex_op          in   [5:0] EX-stage opcode
//   ex_funct       in   [5:0] EX-stage funct field
//   src_a, src_b   in   [DATA_W-1:0] forwarded operands
//   alu_ctrl       out  [2:0] decoded ALU operation
//   alu_result     out  [DATA_W-1:0] combinational result
//   alu_zero       out  alu_result == 0
//   exmem_alu_out  out  [DATA_W-1:0] registered result
//   exmem_zero     out  registered zero flag
//   id_op          in   [5:0] ID-stage opcode
//   id_rs, id_rt   in   [4:0] ID-stage source register numbers
//   exmem_dest     in   [4:0] destination of the EX/MEM instruction
//   memwb_dest     in   [4:0] destination of the MEM/WB instruction
//   bfa_sel        out  [1:0] branch rs source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   bfb_sel        out  [1:0] branch rt source, same encoding
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              stall,
   input  logic [5:0]        ex_op,
   input  logic [5:0]        ex_funct,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic [2:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_result,
   output logic              alu_zero,
   output logic [DATA_W-1:0] exmem_alu_out,
   output logic              exmem_zero,
   input  logic [5:0]        id_op,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        exmem_dest,
   input  logic [4:0]        memwb_dest,
   output logic [1:0]        bfa_sel,
   output logic [1:0]        bfb_sel
);

   localparam logic [2:0] CTRL_AND = 3'b000;
   localparam logic [2:0] CTRL_OR  = 3'b001;
   localparam logic [2:0] CTRL_ADD = 3'b010;
   localparam logic [2:0] CTRL_SUB = 3'b110;
   localparam logic [2:0] CTRL_SLT = 3'b111;

`ifdef ALU_SLT_EN
   localparam logic [2:0] CTRL_SLT_DEC = CTRL_SLT;
`else
   // Without SLT support, set-less-than encodings fall back to ADD.
   localparam logic [2:0] CTRL_SLT_DEC = CTRL_ADD;
`endif

   logic [DATA_W-1:0] exmem_alu_out_q, exmem_alu_out_d;
   logic              exmem_zero_q, exmem_zero_d;

   // ---------------------------------------------------------------- decode
   always_comb begin
      alu_ctrl = CTRL_ADD;
      case (ex_op)
         6'h00: begin
            case (ex_funct)
               6'h20, 6'h21: alu_ctrl = CTRL_ADD;
               6'h22, 6'h23: alu_ctrl = CTRL_SUB;
               6'h24:        alu_ctrl = CTRL_AND;
               6'h25:        alu_ctrl = CTRL_OR;
               6'h2A:        alu_ctrl = CTRL_SLT_DEC;
               default:      alu_ctrl = CTRL_ADD;  // nop, jr, unused functs
            endcase
         end
         6'h23, 6'h2B, 6'h08: alu_ctrl = CTRL_ADD;  // LW, SW, ADDI
         6'h04, 6'h05:        alu_ctrl = CTRL_SUB;  // BEQ, BNE compare
         6'h0C:               alu_ctrl = CTRL_AND;  // ANDI
         6'h0D:               alu_ctrl = CTRL_OR;   // ORI
         6'h0A:               alu_ctrl = CTRL_SLT_DEC;  // SLTI
         default:             alu_ctrl = CTRL_ADD;
      endcase
   end

   // --------------------------------------------------------------- execute
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         CTRL_AND: alu_result = src_a & src_b;
         CTRL_OR:  alu_result = src_a | src_b;
         CTRL_ADD: alu_result = src_a + src_b;
         CTRL_SUB: alu_result = src_a - src_b;
`ifdef ALU_SLT_EN
         CTRL_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
`else
         CTRL_SLT: alu_result = '0;
`endif
         default:  alu_result = '0;  // 011, 100, 101 are unused
      endcase
   end

   assign alu_zero = (alu_result == '0);

   // ------------------------------------------------------ EX/MEM register
   always_comb begin
      exmem_alu_out_d = exmem_alu_out_q;
      exmem_zero_d    = exmem_zero_q;
      if (!stall) begin
         exmem_alu_out_d = alu_result;
         exmem_zero_d    = alu_zero;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exmem_alu_out_q <= '0;
         exmem_zero_q    <= 1'b0;
      end else begin
         exmem_alu_out_q <= exmem_alu_out_d;
         exmem_zero_q    <= exmem_zero_d;
      end
   end

   assign exmem_alu_out = exmem_alu_out_q;
   assign exmem_zero    = exmem_zero_q;

   // ------------------------------------------------- branch forwarding
   // The newer EX/MEM result wins over MEM/WB; register 0 is hardwired to
   // zero so it never forwards. Encoding 11 is unreachable.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] ex_dst,
                                          input logic [4:0] wb_dst);
      logic [1:0] sel;
      sel = 2'b00;
      if (ex_dst != 5'd0 && ex_dst == src) begin
         sel = 2'b01;
      end else if (wb_dst != 5'd0 && wb_dst == src) begin
         sel = 2'b10;
      end
      return sel;
   endfunction

   logic id_is_branch;
   assign id_is_branch = (id_op == 6'h04) || (id_op == 6'h05);

   always_comb begin
      bfa_sel = 2'b00;
      bfb_sel = 2'b00;
      if (id_is_branch) begin
         bfa_sel = fwd_sel(id_rs, exmem_dest, memwb_dest);
         bfb_sel = fwd_sel(id_rt, exmem_dest, memwb_dest);
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed-vector bench for alu_exec_unit (DATA_W = 32). Each scenario task
// drives its stimulus and compares DUT outputs against hand-computed values.
// Build with +define+ALU_SLT_EN to exercise the set-less-than option.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

   localparam int W = 32;

   logic          clock;
   logic          reset_n;
   logic          stall;
   logic [5:0]    ex_op;
   logic [5:0]    ex_funct;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic [2:0]    alu_ctrl;
   logic [W-1:0]  alu_result;
   logic          alu_zero;
   logic [W-1:0]  exmem_alu_out;
   logic          exmem_zero;
   logic [5:0]    id_op;
   logic [4:0]    id_rs;
   logic [4:0]    id_rt;
   logic [4:0]    exmem_dest;
   logic [4:0]    memwb_dest;
   logic [1:0]    bfa_sel;
   logic [1:0]    bfb_sel;

   int vectors;
   int miscompares;

   logic [W-1:0] exp_q[$];
   logic         exp_zq[$];

   alu_exec_unit #(.DATA_W(W)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stall         (stall),
      .ex_op         (ex_op),
      .ex_funct      (ex_funct),
      .src_a         (src_a),
      .src_b         (src_b),
      .alu_ctrl      (alu_ctrl),
      .alu_result    (alu_result),
      .alu_zero      (alu_zero),
      .exmem_alu_out (exmem_alu_out),
      .exmem_zero    (exmem_zero),
      .id_op         (id_op),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .exmem_dest    (exmem_dest),
      .memwb_dest    (memwb_dest),
      .bfa_sel       (bfa_sel),
      .bfb_sel       (bfb_sel)
   );

   // ------------------------------------------------------ clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------ drivers
   task automatic drive_ex(input logic [5:0] op, input logic [5:0] funct,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      ex_op    = op;
      ex_funct = funct;
      src_a    = a;
      src_b    = b;
   endtask

   task automatic drive_id(input logic [5:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] exd,
                           input logic [4:0] wbd);
      id_op      = op;
      id_rs      = rs;
      id_rt      = rt;
      exmem_dest = exd;
      memwb_dest = wbd;
   endtask

   // ---------------------------------------------------------- scenarios
   task automatic test_reset;
      reset_n = 1'b0;
      stall   = 1'b0;
      drive_ex(6'h00, 6'h20, 32'd5, 32'd7);
      drive_id(6'h00, 5'd0, 5'd0, 5'd0, 5'd0);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'd0 || exmem_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_initial: got out=%h zero=%b, want out=0 zero=0",
                  exmem_alu_out, exmem_zero);
      end
      repeat (2) @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'd0 || exmem_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_held: got out=%h zero=%b, want out=0 zero=0",
                  exmem_alu_out, exmem_zero);
      end
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      vectors++;
      if (exmem_alu_out !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_release: got out=%h, want 0 before first edge", exmem_alu_out);
      end
   endtask

   task automatic test_add;
      drive_ex(6'h00, 6'h20, 32'd5, 32'd7);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b010 || alu_result !== 32'd12 || alu_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL add_comb: got ctrl=%b res=%h zero=%b, want 010 0000000c 0",
                  alu_ctrl, alu_result, alu_zero);
      end
      @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'd12 || exmem_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL add_reg: got out=%h zero=%b, want 0000000c 0",
                  exmem_alu_out, exmem_zero);
      end
   endtask

   task automatic test_sub_branch;
      drive_ex(6'h04, 6'h00, 32'h1234, 32'h1234);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b110 || alu_result !== 32'd0 || alu_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL beq_equal: got ctrl=%b res=%h zero=%b, want 110 0 1",
                  alu_ctrl, alu_result, alu_zero);
      end
      @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'd0 || exmem_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL beq_reg: got out=%h zero=%b, want 0 1", exmem_alu_out, exmem_zero);
      end
      drive_ex(6'h00, 6'h22, 32'd0, 32'd1);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b110 || alu_result !== 32'hFFFF_FFFF || alu_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL sub_wrap: got ctrl=%b res=%h zero=%b, want 110 ffffffff 0",
                  alu_ctrl, alu_result, alu_zero);
      end
      drive_ex(6'h00, 6'h23, 32'd100, 32'd58);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b110 || alu_result !== 32'd42) begin
         miscompares++;
         $display("FAIL subu: got ctrl=%b res=%h, want 110 0000002a", alu_ctrl, alu_result);
      end
   endtask

   task automatic test_slt;
`ifdef ALU_SLT_EN
      drive_ex(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b111 || alu_result !== 32'd1 || alu_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL slt_neg: got ctrl=%b res=%h zero=%b, want 111 1 0",
                  alu_ctrl, alu_result, alu_zero);
      end
      drive_ex(6'h0A, 6'h00, 32'd2, 32'd1);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b111 || alu_result !== 32'd0 || alu_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL slti_false: got ctrl=%b res=%h zero=%b, want 111 0 1",
                  alu_ctrl, alu_result, alu_zero);
      end
`else
      drive_ex(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b010 || alu_result !== 32'd0 || alu_zero !== 1'b1) begin
         miscompares++;
         $display("FAIL slt_off: got ctrl=%b res=%h zero=%b, want 010 0 1",
                  alu_ctrl, alu_result, alu_zero);
      end
      drive_ex(6'h0A, 6'h00, 32'd2, 32'd1);
      #1;
      vectors++;
      if (alu_ctrl !== 3'b010 || alu_result !== 32'd3) begin
         miscompares++;
         $display("FAIL slti_off: got ctrl=%b res=%h, want 010 3", alu_ctrl, alu_result);
      end
`endif
   endtask

   task automatic test_forwarding;
      // {id_op, rs, rt, exd, wbd, want_a, want_b}
      logic [5:0] t_op [7];
      logic [4:0] t_rs [7];
      logic [4:0] t_rt [7];
      logic [4:0] t_ex [7];
      logic [4:0] t_wb [7];
      logic [1:0] t_a  [7];
      logic [1:0] t_b  [7];
      t_op = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h23, 6'h05, 6'h04};
      t_rs = '{5'd3,  5'd0,  5'd5,  5'd7,  5'd3,  5'd1,  5'd9};
      t_rt = '{5'd3,  5'd0,  5'd6,  5'd7,  5'd3,  5'd2,  5'd9};
      t_ex = '{5'd3,  5'd0,  5'd0,  5'd7,  5'd3,  5'd0,  5'd4};
      t_wb = '{5'd3,  5'd0,  5'd5,  5'd0,  5'd3,  5'd2,  5'd9};
      t_a  = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
      t_b  = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10};
      for (int i = 0; i < 7; i++) begin
         drive_id(t_op[i], t_rs[i], t_rt[i], t_ex[i], t_wb[i]);
         #1;
         vectors++;
         if (bfa_sel !== t_a[i] || bfb_sel !== t_b[i]) begin
            miscompares++;
            $display("FAIL fwd_%0d: got bfa=%b bfb=%b, want bfa=%b bfb=%b",
                     i, bfa_sel, bfb_sel, t_a[i], t_b[i]);
         end
      end
      drive_id(6'h00, 5'd0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic test_stall;
      @(negedge clock);
      stall = 1'b0;
      drive_ex(6'h00, 6'h20, 32'h55, 32'h0);
      @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'h55) begin
         miscompares++;
         $display("FAIL stall_load: got out=%h, want 00000055", exmem_alu_out);
      end
      stall = 1'b1;
      drive_ex(6'h00, 6'h20, 32'h99, 32'h0);
      #1;
      vectors++;
      if (alu_result !== 32'h99) begin
         miscompares++;
         $display("FAIL stall_comb: got res=%h, want 00000099", alu_result);
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
         vectors++;
         if (exmem_alu_out !== 32'h55 || exmem_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold_%0d: got out=%h zero=%b, want 00000055 0",
                     c, exmem_alu_out, exmem_zero);
         end
      end
      stall = 1'b0;
      @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'h99) begin
         miscompares++;
         $display("FAIL stall_release: got out=%h, want 00000099", exmem_alu_out);
      end
   endtask

   task automatic push_and_check(input logic [5:0] op, input logic [5:0] funct,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] want_ctrl, input logic [W-1:0] want_res);
      logic [W-1:0] e;
      logic         ez;
      drive_ex(op, funct, a, b);
      #1;
      vectors++;
      if (alu_ctrl !== want_ctrl || alu_result !== want_res) begin
         miscompares++;
         $display("FAIL b2b_comb op=%h f=%h: got ctrl=%b res=%h, want %b %h",
                  op, funct, alu_ctrl, alu_result, want_ctrl, want_res);
      end
      exp_q.push_back(want_res);
      exp_zq.push_back(want_res == '0);
      @(posedge clock);
      #1;
      e  = exp_q.pop_front();
      ez = exp_zq.pop_front();
      vectors++;
      if (exmem_alu_out !== e || exmem_zero !== ez) begin
         miscompares++;
         $display("FAIL b2b_reg op=%h f=%h: got out=%h zero=%b, want %h %b",
                  op, funct, exmem_alu_out, exmem_zero, e, ez);
      end
   endtask

   task automatic test_back_to_back;
      stall = 1'b0;
      push_and_check(6'h00, 6'h24, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0);
      push_and_check(6'h00, 6'h25, 32'hF000_0000, 32'h0000_000F, 3'b001, 32'hF000_000F);
      push_and_check(6'h00, 6'h22, 32'h10,        32'h10,        3'b110, 32'h0);
      push_and_check(6'h0C, 6'h00, 32'hFFFF,      32'h1234,      3'b000, 32'h1234);
      push_and_check(6'h0D, 6'h00, 32'h1,         32'h2,         3'b001, 32'h3);
      push_and_check(6'h23, 6'h00, 32'h1000,      32'h4,         3'b010, 32'h1004);
      push_and_check(6'h00, 6'h21, 32'hFFFF_FFFF, 32'h2,         3'b010, 32'h1);
      push_and_check(6'h3F, 6'h22, 32'd3,         32'd4,         3'b010, 32'd7);
      push_and_check(6'h00, 6'h08, 32'd1,         32'd1,         3'b010, 32'd2);
      push_and_check(6'h05, 6'h00, 32'd9,         32'd4,         3'b110, 32'd5);
      push_and_check(6'h2B, 6'h00, 32'h8,         32'hFFFF_FFF8, 3'b010, 32'h0);
   endtask

   task automatic test_async_reset;
      @(negedge clock);
      stall = 1'b1;
      drive_ex(6'h00, 6'h20, 32'h77, 32'h0);
      // Register still holds the last back-to-back value (0, zero=1); load a
      // nonzero value first so the reset has something to clear.
      stall = 1'b0;
      @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'h77) begin
         miscompares++;
         $display("FAIL arst_preload: got out=%h, want 00000077", exmem_alu_out);
      end
      stall = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      vectors++;
      if (exmem_alu_out !== 32'd0 || exmem_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL arst_midcycle: got out=%h zero=%b, want 0 0",
                  exmem_alu_out, exmem_zero);
      end
      vectors++;
      if (alu_result !== 32'h77) begin
         miscompares++;
         $display("FAIL arst_comb: got res=%h, want 00000077", alu_result);
      end
      @(negedge clock);
      reset_n = 1'b1;
      stall   = 1'b0;
      @(posedge clock);
      #1;
      vectors++;
      if (exmem_alu_out !== 32'h77) begin
         miscompares++;
         $display("FAIL arst_first_capture: got out=%h, want 00000077", exmem_alu_out);
      end
   endtask

   // -------------------------------------------------------------- main
   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_add();
      test_sub_branch();
      test_slt();
      test_forwarding();
      test_stall();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; legal values 8..64.
REQ-002 SHALL have one clock and an asynchronous, active-low reset:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
REQ-003 SHALL have these execute-side ports:
- stall  input  1  high holds the output registers
- ex_op  input  6  opcode of the EX-stage instruction
- ex_funct  input  6  funct field of the EX-stage instruction
- src_a  input  DATA_W  forwarded operand A
- src_b  input  DATA_W  forwarded operand B
- alu_ctrl  output  3  decoded ALU operation
- alu_result  output  DATA_W  combinational result
- alu_zero  output  1  alu_result equals 0
- exmem_alu_out  output  DATA_W  registered result
- exmem_zero  output  1  registered zero flag
REQ-004 SHALL have these branch-forwarding ports:
- id_op  input  6  opcode of the ID-stage instruction
- id_rs  input  5  rs field of the ID-stage instruction
- id_rt  input  5  rt field of the ID-stage instruction
- exmem_dest  input  5  destination register of the EX/MEM instruction
- memwb_dest  input  5  destination register of the MEM/WB instruction
- bfa_sel  output  2  source select for branch operand rs
- bfb_sel  output  2  source select for branch operand rt

Function
REQ-005 SHALL decode alu_ctrl combinationally from ex_op and ex_funct.
- ex_op 0x00 (R-type), by funct: 0x20/0x21 -> 010 ADD; 0x22/0x23 -> 110 SUB; 0x24 -> 000 AND; 0x25 -> 001 OR; 0x2A -> 111 SLT; any other funct (including 0x00 nop and 0x08 jr) -> 010.
- ex_op 0x23 LW, 0x2B SW, 0x08 ADDI -> 010.
- ex_op 0x04 BEQ, 0x05 BNE -> 110.
- ex_op 0x0C -> 000; 0x0D -> 001; 0x0A -> 111.
- Any other opcode -> 010.
REQ-006 SHALL compute alu_result combinationally from alu_ctrl:
- 000: src_a AND src_b.
- 001: src_a OR src_b.
- 010: src_a + src_b, modulo 2^DATA_W, carry discarded.
- 110: src_a - src_b, modulo 2^DATA_W, borrow discarded.
- 111: see REQ-016.
- 011, 100, 101: all-zero result.
REQ-007 SHALL drive alu_zero = 1 exactly when alu_result is all zeros, in the same cycle.
REQ-008 SHALL, on a rising clock edge with stall = 0, load exmem_alu_out <= alu_result and exmem_zero <= alu_zero; latency is one cycle.
REQ-009 SHALL, on a rising clock edge with stall = 1, hold exmem_alu_out and exmem_zero unchanged; alu_ctrl, alu_result and alu_zero keep following their inputs.
REQ-010 SHALL compute bfa_sel/bfb_sel combinationally, and only when id_op is 0x04 or 0x05; for any other id_op both SHALL be 00.
REQ-011 SHALL, for a branch, set bfa_sel as follows (first match wins):
- exmem_dest != 0 and exmem_dest == id_rs -> 01.
- memwb_dest != 0 and memwb_dest == id_rs -> 10.
- otherwise -> 00 (register file).
REQ-012 SHALL derive bfb_sel identically to REQ-011, using id_rt in place of id_rs.
REQ-013 SHALL give EX/MEM priority over MEM/WB when both destinations match; register 0 SHALL never select a forward; encoding 11 SHALL never be driven.

Reset
REQ-014 SHALL, while reset_n = 0, immediately force exmem_alu_out = 0 and exmem_zero = 0, independent of clock and stall.
REQ-015 SHALL NOT reset the combinational outputs (alu_ctrl, alu_result, alu_zero, bfa_sel, bfb_sel); the first capture SHALL occur on the first rising edge after reset_n rises with stall = 0.

Configuration
REQ-016 SHALL support macro ALU_SLT_EN:
- Defined: alu_ctrl 111 yields 1 when src_a < src_b as signed two's complement, otherwise 0, zero-extended to DATA_W.
- Undefined: alu_ctrl 111 yields all zeros, and funct 0x2A and opcode 0x0A decode to 010.

Verification
REQ-017 SHALL be verified with these directed scenarios:
- ex_op=0x00, funct=0x20, src_a=5, src_b=7 -> alu_ctrl=010, alu_result=12; after one edge exmem_alu_out=12, exmem_zero=0.
- ex_op=0x04, src_a=src_b=0x1234 -> alu_ctrl=110, alu_zero=1; SUB 0 - 1 -> 0xFFFFFFFF (wrap-around).
- ALU_SLT_EN defined, funct=0x2A, src_a=0xFFFFFFFF, src_b=1 -> alu_result=1; macro undefined -> alu_ctrl=010, alu_result=0.
- id_op=0x04, id_rs=3, id_rt=3, exmem_dest=3, memwb_dest=3 -> bfa_sel=bfb_sel=01; exmem_dest=0, memwb_dest=0, id_rs=0 -> 00; id_op=0x23 with matches -> 00.
- Load 0x55, then stall=1 for 3 cycles with a new result 0x99 -> exmem_alu_out stays 0x55; after stall falls, one edge -> 0x99.
- Assert reset_n=0 mid-cycle between edges -> exmem_alu_out=0 and exmem_zero=0 before the next edge.
